pmem_arbiter: RTL and testbench

- Three-client arbiter between the cacheline-granularity clients and the single physical-memory port: I-side (i), LSQ/D-side (lsq) and next-line prefetcher (pref).
- Sits directly downstream of the prefetcher. Consumes its read request and supplies its response.
- Produces arbiter_idle, which the prefetcher uses to issue only into an otherwise idle memory system.
- One transaction in flight. Non-preemptive. Per-client 256-bit line transfers.

---
 rtl/pmem_arb_pkg.sv | 27 ++
 rtl/pmem_arbiter_sat_counter.sv | 30 +++
 rtl/pmem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_pmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_arb_pkg.sv
// +------------------------------------------------------------------+
// | pmem_arb_pkg : shared types and widths for the pmem arbiter      |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
`default_nettype none

package pmem_arb_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        I    = 2'd1,
        LSQ  = 2'd2,
        PREF = 2'd3
    } client_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pmem_arbiter_sat_counter.sv
// +------------------------------------------------------------------+
// | sat_counter : saturating up-counter, holds at all-ones           |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pmem_arbiter.sv
// +------------------------------------------------------------------+
// | pmem_arbiter : non-preemptive I/LSQ/prefetch arbiter for pmem    |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
`default_nettype none

module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int PERF_W      = 32,
    parameter bit PREF_ENABLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read_cla,
    input  logic              i_pmem_write_cla,
    input  logic [ADDR_W-1:0] i_pmem_address_cla,
    input  logic [LINE_W-1:0] i_pmem_wdata_256_cla,
    output logic              i_pmem_resp_cla,
    output logic [LINE_W-1:0] i_pmem_rdata_256_cla,

    input  logic              lsq_pmem_read_cla,
    input  logic              lsq_pmem_write_cla,
    input  logic [ADDR_W-1:0] lsq_pmem_address_cla,
    input  logic [LINE_W-1:0] lsq_pmem_wdata_256_cla,
    output logic              lsq_pmem_resp_cla,
    output logic [LINE_W-1:0] lsq_pmem_rdata_256_cla,

    input  logic              pref_pmem_read_cla,
    input  logic              pref_pmem_write_cla,
    input  logic [ADDR_W-1:0] pref_pmem_address_cla,
    input  logic [LINE_W-1:0] pref_pmem_wdata_256_cla,
    output logic              pref_pmem_resp_cla,
    output logic [LINE_W-1:0] pref_pmem_rdata_256_cla,

    output logic              arbiter_idle,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,

    output logic [PERF_W-1:0] perf_i_grants,
    output logic [PERF_W-1:0] perf_lsq_grants,
    output logic [PERF_W-1:0] perf_pref_grants
);

    state_e              state_q, state_d;
    client_e             owner_q, owner_d;
    client_e             rr_last_q, rr_last_d;
    client_e             winner;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;

    logic i_req, lsq_req, pref_req;
    logic busy, resp_fire;
    logic unused_pref;

    // The prefetcher is read-only; its write strobe and data are dropped.
    assign unused_pref = ^{pref_pmem_write_cla, pref_pmem_wdata_256_cla};

    assign i_req    = i_pmem_read_cla | i_pmem_write_cla;
    assign lsq_req  = lsq_pmem_read_cla | lsq_pmem_write_cla;
    assign pref_req = pref_pmem_read_cla & PREF_ENABLE;

    always_comb begin
        winner = NONE;
        if (i_req && lsq_req) begin
            winner = (rr_last_q == LSQ) ? I : LSQ;
        end else if (i_req) begin
            winner = I;
        end else if (lsq_req) begin
            winner = LSQ;
        end else if (pref_req) begin
            winner = PREF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= NONE;
            rr_last_q <= LSQ;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (winner != NONE) begin
                    state_d = BUSY;
                    owner_d = winner;
                end
                case (winner)
                    I: begin
                        rr_last_d = I;
                        write_d   = i_pmem_write_cla;
                        addr_d    = i_pmem_address_cla;
                        wdata_d   = i_pmem_wdata_256_cla;
                    end
                    LSQ: begin
                        rr_last_d = LSQ;
                        write_d   = lsq_pmem_write_cla;
                        addr_d    = lsq_pmem_address_cla;
                        wdata_d   = lsq_pmem_wdata_256_cla;
                    end
                    PREF: begin
                        write_d   = 1'b0;
                        addr_d    = pref_pmem_address_cla;
                        wdata_d   = '0;
                    end
                    default: ;
                endcase
            end
            BUSY: begin
                if (pmem_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                owner_d = NONE;
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
            end
        endcase
    end

    assign busy      = (state_q == BUSY);
    assign resp_fire = busy & pmem_resp;

    assign pmem_read    = busy & ~write_q;
    assign pmem_write   = busy & write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp_cla    = resp_fire && (owner_q == I);
    assign lsq_pmem_resp_cla  = resp_fire && (owner_q == LSQ);
    assign pref_pmem_resp_cla = resp_fire && (owner_q == PREF);

    assign i_pmem_rdata_256_cla    = (busy && owner_q == I)    ? pmem_rdata : '0;
    assign lsq_pmem_rdata_256_cla  = (busy && owner_q == LSQ)  ? pmem_rdata : '0;
    assign pref_pmem_rdata_256_cla = (busy && owner_q == PREF) ? pmem_rdata : '0;

    // Reset term keeps the prefetcher quiet while the arbiter is held in reset.
    assign arbiter_idle = rst && (state_q == IDLE) && !i_req && !lsq_req;

    sat_counter #(.W(PERF_W)) u_cnt_i (
        .clk     (clk),
        .rst     (rst),
        .inc_i   ((state_q == IDLE) && (winner == I)),
        .count_o (perf_i_grants)
    );

    sat_counter #(.W(PERF_W)) u_cnt_lsq (
        .clk     (clk),
        .rst     (rst),
        .inc_i   ((state_q == IDLE) && (winner == LSQ)),
        .count_o (perf_lsq_grants)
    );

    sat_counter #(.W(PERF_W)) u_cnt_pref (
        .clk     (clk),
        .rst     (rst),
        .inc_i   ((state_q == IDLE) && (winner == PREF)),
        .count_o (perf_pref_grants)
    );

endmodule

`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
// +------------------------------------------------------------------+
// | tb_pmem_arbiter : directed bench for pmem_arbiter + variants     |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_rd, i_wr, lsq_rd, lsq_wr, pf_rd, pf_wr;
    logic [31:0]  i_addr, lsq_addr, pf_addr;
    logic [255:0] i_wd, lsq_wd, pf_wd;
    logic         mem_resp;
    logic [255:0] mem_rdata;

    // main instance (defaults)
    logic         i_resp, lsq_resp, pf_resp, idle, p_rd, p_wr;
    logic [255:0] i_rdata, lsq_rdata, pf_rdata, p_wd;
    logic [31:0]  p_addr, perf_i, perf_lsq, perf_pf;
    // 2-bit counter instance
    logic         s_i_resp, s_lsq_resp, s_pf_resp, s_idle, s_rd, s_wr;
    logic [255:0] s_i_rdata, s_lsq_rdata, s_pf_rdata, s_wd;
    logic [31:0]  s_addr;
    logic [1:0]   s_perf_i, s_perf_lsq, s_perf_pf;
    // prefetch-disabled instance
    logic         n_i_resp, n_lsq_resp, n_pf_resp, n_idle, n_rd, n_wr;
    logic [255:0] n_i_rdata, n_lsq_rdata, n_pf_rdata, n_wd;
    logic [31:0]  n_addr, n_perf_i, n_perf_lsq, n_perf_pf;

    int passed = 0;
    int total  = 0;

    localparam logic [255:0] LINE_A5 = {32{8'hA5}};
    localparam logic [255:0] LINE_B7 = {32{8'hB7}};
    localparam logic [255:0] LINE_DE = {8{32'hDEAD_BEEF}};

    always #5 clk = ~clk;

    pmem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_pmem_read_cla(i_rd), .i_pmem_write_cla(i_wr), .i_pmem_address_cla(i_addr),
        .i_pmem_wdata_256_cla(i_wd), .i_pmem_resp_cla(i_resp), .i_pmem_rdata_256_cla(i_rdata),
        .lsq_pmem_read_cla(lsq_rd), .lsq_pmem_write_cla(lsq_wr), .lsq_pmem_address_cla(lsq_addr),
        .lsq_pmem_wdata_256_cla(lsq_wd), .lsq_pmem_resp_cla(lsq_resp), .lsq_pmem_rdata_256_cla(lsq_rdata),
        .pref_pmem_read_cla(pf_rd), .pref_pmem_write_cla(pf_wr), .pref_pmem_address_cla(pf_addr),
        .pref_pmem_wdata_256_cla(pf_wd), .pref_pmem_resp_cla(pf_resp), .pref_pmem_rdata_256_cla(pf_rdata),
        .arbiter_idle(idle), .pmem_read(p_rd), .pmem_write(p_wr), .pmem_address(p_addr),
        .pmem_wdata(p_wd), .pmem_resp(mem_resp), .pmem_rdata(mem_rdata),
        .perf_i_grants(perf_i), .perf_lsq_grants(perf_lsq), .perf_pref_grants(perf_pf)
    );

    pmem_arbiter #(.PERF_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .i_pmem_read_cla(i_rd), .i_pmem_write_cla(i_wr), .i_pmem_address_cla(i_addr),
        .i_pmem_wdata_256_cla(i_wd), .i_pmem_resp_cla(s_i_resp), .i_pmem_rdata_256_cla(s_i_rdata),
        .lsq_pmem_read_cla(lsq_rd), .lsq_pmem_write_cla(lsq_wr), .lsq_pmem_address_cla(lsq_addr),
        .lsq_pmem_wdata_256_cla(lsq_wd), .lsq_pmem_resp_cla(s_lsq_resp), .lsq_pmem_rdata_256_cla(s_lsq_rdata),
        .pref_pmem_read_cla(pf_rd), .pref_pmem_write_cla(pf_wr), .pref_pmem_address_cla(pf_addr),
        .pref_pmem_wdata_256_cla(pf_wd), .pref_pmem_resp_cla(s_pf_resp), .pref_pmem_rdata_256_cla(s_pf_rdata),
        .arbiter_idle(s_idle), .pmem_read(s_rd), .pmem_write(s_wr), .pmem_address(s_addr),
        .pmem_wdata(s_wd), .pmem_resp(mem_resp), .pmem_rdata(mem_rdata),
        .perf_i_grants(s_perf_i), .perf_lsq_grants(s_perf_lsq), .perf_pref_grants(s_perf_pf)
    );

    pmem_arbiter #(.PREF_ENABLE(1'b0)) dut_n (
        .clk(clk), .rst(rst),
        .i_pmem_read_cla(i_rd), .i_pmem_write_cla(i_wr), .i_pmem_address_cla(i_addr),
        .i_pmem_wdata_256_cla(i_wd), .i_pmem_resp_cla(n_i_resp), .i_pmem_rdata_256_cla(n_i_rdata),
        .lsq_pmem_read_cla(lsq_rd), .lsq_pmem_write_cla(lsq_wr), .lsq_pmem_address_cla(lsq_addr),
        .lsq_pmem_wdata_256_cla(lsq_wd), .lsq_pmem_resp_cla(n_lsq_resp), .lsq_pmem_rdata_256_cla(n_lsq_rdata),
        .pref_pmem_read_cla(pf_rd), .pref_pmem_write_cla(pf_wr), .pref_pmem_address_cla(pf_addr),
        .pref_pmem_wdata_256_cla(pf_wd), .pref_pmem_resp_cla(n_pf_resp), .pref_pmem_rdata_256_cla(n_pf_rdata),
        .arbiter_idle(n_idle), .pmem_read(n_rd), .pmem_write(n_wr), .pmem_address(n_addr),
        .pmem_wdata(n_wd), .pmem_resp(mem_resp), .pmem_rdata(mem_rdata),
        .perf_i_grants(n_perf_i), .perf_lsq_grants(n_perf_lsq), .perf_pref_grants(n_perf_pf)
    );

    // Each cycle: inputs change 1 unit after the rising edge, outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        i_rd = 0; i_wr = 0; i_addr = '0; i_wd = '0;
        lsq_rd = 0; lsq_wr = 0; lsq_addr = '0; lsq_wd = '0;
        pf_rd = 0; pf_wr = 0; pf_addr = '0; pf_wd = '0;
        mem_resp = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 0;
        clear_inputs();
        tick();
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        tick();
        tick();
        total++; if (idle !== 1'b0) $display("FAIL reset_idle: got %b want 0", idle); else passed++;
        total++; if ({p_rd, p_wr} !== 2'b00) $display("FAIL reset_pmem_rw: got %b want 00", {p_rd, p_wr}); else passed++;
        total++; if (p_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", p_addr); else passed++;
        total++; if ({perf_i, perf_lsq, perf_pf} !== 96'h0) $display("FAIL reset_perf: got %h want 0", {perf_i, perf_lsq, perf_pf}); else passed++;
        rst = 1;
        settle();
        total++; if (idle !== 1'b1) $display("FAIL reset_release_idle: got %b want 1", idle); else passed++;
    endtask

    task automatic test_lone_lsq();
        do_reset();
        lsq_rd = 1; lsq_addr = 32'h0000_1000;
        settle();
        total++; if (idle !== 1'b0) $display("FAIL lone_idle_on_req: got %b want 0", idle); else passed++;
        total++; if (p_rd !== 1'b0) $display("FAIL lone_rd_c0: got %b want 0", p_rd); else passed++;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 5) begin mem_resp = 1; mem_rdata = LINE_A5; end
            settle();
            total++; if (p_rd !== 1'b1 || p_addr !== 32'h1000) $display("FAIL lone_busy c%0d: rd=%b addr=%h want rd=1 addr=1000", c, p_rd, p_addr); else passed++;
            total++; if (lsq_resp !== (c == 5)) $display("FAIL lone_resp c%0d: got %b want %b", c, lsq_resp, (c == 5)); else passed++;
        end
        total++; if (lsq_rdata !== LINE_A5) $display("FAIL lone_rdata: got %h want %h", lsq_rdata, LINE_A5); else passed++;
        total++; if (i_rdata !== 256'h0) $display("FAIL lone_other_rdata: got %h want 0", i_rdata); else passed++;
        total++; if (perf_lsq !== 32'd1) $display("FAIL lone_perf_lsq: got %0d want 1", perf_lsq); else passed++;
        tick();
        mem_resp = 0; lsq_rd = 0;
        settle();
        total++; if (p_rd !== 1'b0 || lsq_resp !== 1'b0 || idle !== 1'b0) $display("FAIL lone_done: rd=%b resp=%b idle=%b want 0 0 0", p_rd, lsq_resp, idle); else passed++;
        tick();
        settle();
        total++; if (idle !== 1'b1) $display("FAIL lone_back_idle: got %b want 1", idle); else passed++;
    endtask

    task automatic test_round_robin();
        do_reset();
        i_rd = 1; i_addr = 32'h100; lsq_rd = 1; lsq_addr = 32'h200;
        tick(); settle();
        total++; if (p_addr !== 32'h100) $display("FAIL rr_first_grant: got addr %h want 100", p_addr); else passed++;
        tick(); mem_resp = 1; settle();
        total++; if ({i_resp, lsq_resp} !== 2'b10) $display("FAIL rr_first_resp: got i/lsq %b want 10", {i_resp, lsq_resp}); else passed++;
        tick(); mem_resp = 0; i_rd = 0;
        tick(); i_rd = 1;
        tick(); settle();
        total++; if (p_addr !== 32'h200 || p_rd !== 1'b1) $display("FAIL rr_second_grant: got addr %h rd %b want 200 1", p_addr, p_rd); else passed++;
        tick(); mem_resp = 1; settle();
        total++; if ({i_resp, lsq_resp} !== 2'b01) $display("FAIL rr_second_resp: got i/lsq %b want 01", {i_resp, lsq_resp}); else passed++;
        tick(); mem_resp = 0; lsq_rd = 0;
        tick();
        tick(); settle();
        total++; if (p_addr !== 32'h100 || p_rd !== 1'b1) $display("FAIL rr_third_grant: got addr %h rd %b want 100 1", p_addr, p_rd); else passed++;
        total++; if (perf_i !== 32'd2 || perf_lsq !== 32'd1) $display("FAIL rr_perf: got i=%0d lsq=%0d want 2 1", perf_i, perf_lsq); else passed++;
        tick(); mem_resp = 1;
        tick(); mem_resp = 0; i_rd = 0;
        tick();
    endtask

    task automatic test_write_and_stray_resp();
        do_reset();
        lsq_rd = 1; lsq_wr = 1; lsq_addr = 32'h0000_4440; lsq_wd = LINE_DE;
        tick(); settle();
        total++; if ({p_rd, p_wr} !== 2'b01) $display("FAIL wr_wins: got rd/wr %b want 01", {p_rd, p_wr}); else passed++;
        total++; if (p_wd !== LINE_DE || p_addr !== 32'h4440) $display("FAIL wr_data: got %h @%h want %h @4440", p_wd, p_addr, LINE_DE); else passed++;
        tick(); mem_resp = 1; settle();
        total++; if (lsq_resp !== 1'b1) $display("FAIL wr_resp: got %b want 1", lsq_resp); else passed++;
        tick(); lsq_rd = 0; lsq_wr = 0; settle();
        total++; if ({i_resp, lsq_resp, pf_resp} !== 3'b000) $display("FAIL stray_resp_done: got %b want 000", {i_resp, lsq_resp, pf_resp}); else passed++;
        tick(); settle();
        total++; if ({i_resp, lsq_resp, pf_resp} !== 3'b000 || idle !== 1'b1) $display("FAIL stray_resp_idle: resp=%b idle=%b want 000 1", {i_resp, lsq_resp, pf_resp}, idle); else passed++;
        mem_resp = 0;
    endtask

    task automatic test_pref_then_i();
        do_reset();
        pf_rd = 1; pf_addr = 32'h2020;
        settle();
        total++; if (idle !== 1'b1) $display("FAIL pf_idle_own_req: got %b want 1", idle); else passed++;
        tick(); i_rd = 1; i_addr = 32'h300; settle();
        total++; if (p_rd !== 1'b1 || p_addr !== 32'h2020 || idle !== 1'b0) $display("FAIL pf_busy: rd=%b addr=%h idle=%b want 1 2020 0", p_rd, p_addr, idle); else passed++;
        tick(); settle();
        total++; if (p_addr !== 32'h2020) $display("FAIL pf_no_preempt: got addr %h want 2020", p_addr); else passed++;
        tick(); mem_resp = 1; mem_rdata = LINE_B7; settle();
        total++; if ({i_resp, pf_resp} !== 2'b01 || pf_rdata !== LINE_B7) $display("FAIL pf_resp: i/pf %b rdata %h want 01 %h", {i_resp, pf_resp}, pf_rdata, LINE_B7); else passed++;
        tick(); mem_resp = 0; pf_rd = 0; settle();
        total++; if (p_rd !== 1'b0 || idle !== 1'b0) $display("FAIL pf_done: rd=%b idle=%b want 0 0", p_rd, idle); else passed++;
        tick(); settle();
        total++; if (p_rd !== 1'b0 || idle !== 1'b0) $display("FAIL pf_gap_idle: rd=%b idle=%b want 0 0", p_rd, idle); else passed++;
        tick(); settle();
        total++; if (p_rd !== 1'b1 || p_addr !== 32'h300) $display("FAIL pf_then_i_grant: rd=%b addr=%h want 1 300", p_rd, p_addr); else passed++;
        tick(); mem_resp = 1; settle();
        total++; if (i_resp !== 1'b1) $display("FAIL pf_then_i_resp: got %b want 1", i_resp); else passed++;
        tick(); mem_resp = 0; i_rd = 0;
        tick();
    endtask

    task automatic test_pref_vs_lsq();
        do_reset();
        pf_rd = 1; pf_addr = 32'h5000; lsq_rd = 1; lsq_addr = 32'h6000;
        tick(); settle();
        total++; if (p_addr !== 32'h6000 || n_addr !== 32'h6000) $display("FAIL pvl_lsq_first: got %h/%h want 6000", p_addr, n_addr); else passed++;
        tick(); mem_resp = 1;
        tick(); mem_resp = 0; lsq_rd = 0;
        tick(); settle();
        total++; if (p_rd !== 1'b0) $display("FAIL pvl_idle_gap: got rd %b want 0", p_rd); else passed++;
        tick(); settle();
        total++; if (p_rd !== 1'b1 || p_addr !== 32'h5000) $display("FAIL pvl_pref_grant: rd=%b addr=%h want 1 5000", p_rd, p_addr); else passed++;
        total++; if (n_rd !== 1'b0 || n_perf_pf !== 32'd0) $display("FAIL pvl_disabled_grant: rd=%b perf=%0d want 0 0", n_rd, n_perf_pf); else passed++;
        tick(); mem_resp = 1; settle();
        total++; if (pf_resp !== 1'b1 || n_pf_resp !== 1'b0) $display("FAIL pvl_pref_resp: main=%b disabled=%b want 1 0", pf_resp, n_pf_resp); else passed++;
        tick(); mem_resp = 0; pf_rd = 0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        i_rd = 1; i_addr = 32'h400;
        tick(); settle();
        total++; if (p_rd !== 1'b1 || perf_i !== 32'd1) $display("FAIL rmb_pre: rd=%b perf=%0d want 1 1", p_rd, perf_i); else passed++;
        #1 rst = 0;
        #1;
        total++; if (p_rd !== 1'b0 || i_resp !== 1'b0 || idle !== 1'b0) $display("FAIL rmb_async: rd=%b resp=%b idle=%b want 0 0 0", p_rd, i_resp, idle); else passed++;
        total++; if (perf_i !== 32'd0 || p_addr !== 32'h0) $display("FAIL rmb_clear: perf=%0d addr=%h want 0 0", perf_i, p_addr); else passed++;
        i_rd = 0;
        #1 rst = 1;
        tick(); settle();
        total++; if (idle !== 1'b1 || p_rd !== 1'b0) $display("FAIL rmb_after: idle=%b rd=%b want 1 0", idle, p_rd); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            pf_rd = 1; pf_addr = 32'h3000 + 32'(k) * 32'h20;
            tick(); mem_resp = 1; settle();
            total++; if (pf_resp !== 1'b1 || n_pf_resp !== 1'b0) $display("FAIL sat_resp k%0d: main=%b disabled=%b want 1 0", k, pf_resp, n_pf_resp); else passed++;
            tick(); mem_resp = 0; pf_rd = 0;
            tick();
        end
        total++; if (s_perf_pf !== 2'd3) $display("FAIL sat_narrow: got %0d want 3", s_perf_pf); else passed++;
        total++; if (perf_pf !== 32'd5) $display("FAIL sat_wide: got %0d want 5", perf_pf); else passed++;
        total++; if (n_perf_pf !== 32'd0) $display("FAIL sat_disabled: got %0d want 0", n_perf_pf); else passed++;
    endtask

    initial begin
        test_reset();
        test_lone_lsq();
        test_round_robin();
        test_write_and_stray_resp();
        test_pref_then_i();
        test_pref_vs_lsq();
        test_reset_mid_busy();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
